// File: rtl/diff_amp_cal_ctrl.sv
// Offset-calibration sequencer for the on-chip differential amplifier.
// Powers the amp, shorts its inputs and runs a SAR search on the trim code.
// The synchronized comparator output drives each decision. The best code is
// left applied to the amp, and done/cal_ok report the result.
module diff_amp_cal_ctrl #(
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 16,
    parameter int SAMPLES    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              man_load,
    input  logic [TRIM_W-1:0] man_code,
    input  logic              cmp_in,
    output logic [TRIM_W-1:0] trim_code,
    output logic              bias_en,
    output logic              short_en,
    output logic              busy,
    output logic              done,
    output logic              cal_ok
);

    localparam int CNT_MAX = (SETTLE_CYC > SAMPLES) ? SETTLE_CYC : SAMPLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int OW      = $clog2(SAMPLES + 1);
    localparam int IW      = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

    localparam logic [TRIM_W-1:0] MIDSCALE    = {1'b1, {(TRIM_W-1){1'b0}}};
    localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]     SAMPLE_LAST = CW'(SAMPLES - 1);
    localparam logic [OW:0]       SAMPLES_V   = (OW + 1)'(SAMPLES);
    localparam logic [IW-1:0]     IDX_TOP     = IW'(TRIM_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_SET,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DECIDE,
        ST_FIN
    } state_t;

    state_t            state;
    logic [TRIM_W-1:0] saved_code;
    logic [CW-1:0]     cnt;
    logic [OW-1:0]     ones;
    logic [IW-1:0]     idx;
    logic              cmp_meta;
    logic              cmp_s;
    logic [OW:0]       ones_x2;

    // Twice the high-sample count, compared against SAMPLES for a strict majority
    assign ones_x2 = {ones, 1'b0};

    // Two-flop synchronizer for the asynchronous comparator output
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

    // Calibration sequencer with registered analog controls and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            trim_code  <= MIDSCALE;
            saved_code <= MIDSCALE;
            bias_en    <= 1'b0;
            short_en   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cal_ok     <= 1'b0;
            cnt        <= '0;
            ones       <= '0;
            idx        <= IDX_TOP;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && abort) begin
                // Abort drops back to the last good code; bias stays powered
                state     <= ST_IDLE;
                busy      <= 1'b0;
                short_en  <= 1'b0;
                trim_code <= saved_code;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state     <= ST_PWRUP;
                            bias_en   <= 1'b1;
                            short_en  <= 1'b1;
                            busy      <= 1'b1;
                            trim_code <= '0;
                            idx       <= IDX_TOP;
                            cnt       <= '0;
                        end else if (man_load) begin
                            trim_code  <= man_code;
                            saved_code <= man_code;
                        end
                    end
                    ST_PWRUP: begin
                        if (cnt == SETTLE_LAST) begin
                            state <= ST_SET;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_SET: begin
                        trim_code[idx] <= 1'b1;
                        ones           <= '0;
                        cnt            <= '0;
                        state          <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            state <= ST_SAMPLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        if (cmp_s) begin
                            ones <= ones + 1'b1;
                        end
                        if (cnt == SAMPLE_LAST) begin
                            state <= ST_DECIDE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DECIDE: begin
                        // Majority high means the trial code overshoots
                        if (ones_x2 > SAMPLES_V) begin
                            trim_code[idx] <= 1'b0;
                        end
                        if (idx != '0) begin
                            idx   <= idx - 1'b1;
                            state <= ST_SET;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                    ST_FIN: begin
                        done       <= 1'b1;
                        short_en   <= 1'b0;
                        busy       <= 1'b0;
                        saved_code <= trim_code;
                        cal_ok     <= (trim_code != '0) && (trim_code != '1);
                        state      <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
